// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } boot_state_t;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * WORD_BYTES;
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte stream in, instruction-memory write port and core release out.
interface imem_boot_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_run;
    logic        done;
    logic        error;

    // The loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, core_run, done, error
    );

    // The stream source / observer side.
    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_run, done, error
    );

endinterface

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Collects four accepted bytes, least-significant first, into one 32-bit word.
module byte_word_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shreg_q, shreg_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (byte_en) begin
            idx_d   = idx_q + 2'd1;
            shreg_d = {byte_in, shreg_q[23:8]};
        end
    end

    // The 4th byte completes the word combinationally so the caller acts on the same edge.
    assign word_valid = byte_en && (idx_q == 2'(WORD_BYTES - 1));
    assign word       = {byte_in, shreg_q};

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses header, writes payload words to instruction memory,
// verifies the XOR checksum and then releases the core.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave bus
);

    // One extra bit so the word index can reach N == IMEM_WORDS.
    localparam int AW = $clog2(IMEM_WORDS) + 1;

    boot_state_t state_q, state_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [AW-1:0] n_q, n_d;
    logic [7:0]    xor_q, xor_d;

    logic        in_ready_q, in_ready_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        run_q, run_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        accept;
    logic        asm_en;
    logic [31:0] asm_word;
    logic        asm_valid;

    assign accept = bus.in_valid && in_ready_q;
    assign asm_en = accept && ((state_q == HDR) || (state_q == DATA));

    byte_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_en    (asm_en),
        .byte_in    (bus.in_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        n_d     = n_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            HDR: begin
                if (asm_valid) begin
                    // Full 32-bit compare: a count that only looks small in its low bits is still rejected.
                    if (asm_word > 32'(IMEM_WORDS)) begin
                        state_d = ERR;
                    end else if (asm_word == 32'd0) begin
                        state_d = CHK;
                    end else begin
                        n_d     = asm_word[AW-1:0];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    xor_d = xor_q ^ bus.in_data;
                end
                if (asm_valid) begin
                    we_d    = 1'b1;
                    addr_d  = word_addr(BASE_ADDR, 32'(widx_q));
                    wdata_d = asm_word;
                    widx_d  = widx_q + 1'b1;
                    if (widx_d == n_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    state_d = (bus.in_data == xor_q) ? DONE : ERR;
                end
            end
            default: ;
        endcase

        in_ready_d = (state_d == HDR) || (state_d == DATA) || (state_d == CHK);
        run_d      = (state_d == DONE);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= HDR;
            widx_q     <= '0;
            n_q        <= '0;
            xor_q      <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            n_q        <= n_d;
            xor_q      <= xor_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            run_q      <= run_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_run   = run_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; a small IMEM_WORDS keeps the capacity boundary cheap to reach.
module tb_imem_boot_loader;

    localparam int IMEM_WORDS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_boot_loader_if bus();

    imem_boot_loader #(
        .IMEM_WORDS (IMEM_WORDS),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Per-run log, sampled at the falling edge; cycle numbers start at 1.
    int          cyc;
    int          acc_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc;
    int          err_cyc;

    logic [7:0] img[$];
    logic [7:0] csum;

    task automatic clear_log();
        cyc = 0;
        acc_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    // One clock: observe last edge's outputs, then present inputs for the next edge.
    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clk);
        cyc++;
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (bus.error === 1'b1 && err_cyc < 0) err_cyc = cyc;
        bus.in_valid = v;
        bus.in_data  = d;
        if (v && bus.in_ready === 1'b1) acc_cyc.push_back(cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic new_image(input logic [31:0] n);
        img.delete();
        csum = 8'h00;
        for (int i = 0; i < 4; i++) img.push_back(n[8*i +: 8]);
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            img.push_back(w[8*i +: 8]);
            csum = csum ^ w[8*i +: 8];
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        img.push_back(b);
    endtask

    // gap_mode 1 inserts (i % 3) idle cycles before byte i. Trailing bytes probe in_ready=0.
    task automatic send_image(input int gap_mode, output int gaps);
        gaps = 0;
        for (int i = 0; i < img.size(); i++) begin
            if (gap_mode == 1) begin
                repeat (i % 3) step(1'b0, 8'h00);
                gaps += i % 3;
            end
            step(1'b1, img[i]);
        end
        repeat (4) step(1'b1, 8'hA5);
        step(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.imem_we); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.imem_wdata); end
        checks++; if (bus.core_run !== 1'b0) begin errors++; $display("FAIL rst_core_run: got %b want 0", bus.core_run); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", bus.error); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_full_rate();
        int g;
        do_reset();
        new_image(32'd2);
        add_word(32'h1122_3344);
        add_word(32'hAABB_CCDD);
        add_byte(csum);
        clear_log();
        send_image(0, g);
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL full_wr_count: got %0d want 2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            checks++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h1122_3344) begin errors++; $display("FAIL full_wr0: got %h/%h want 00000000/11223344", wr_addr[0], wr_data[0]); end
            checks++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'hAABB_CCDD) begin errors++; $display("FAIL full_wr1: got %h/%h want 00000004/aabbccdd", wr_addr[1], wr_data[1]); end
            checks++; if (wr_cyc[0] != 9 || wr_cyc[1] != 13) begin errors++; $display("FAIL full_wr_cycles: got %0d,%0d want 9,13", wr_cyc[0], wr_cyc[1]); end
        end
        checks++; if (done_cyc != 14) begin errors++; $display("FAIL full_done_cycle: got %0d want 14", done_cyc); end
        checks++; if (bus.core_run !== 1'b1 || bus.done !== 1'b1 || bus.error !== 1'b0) begin errors++; $display("FAIL full_outputs: run/done/err got %b%b%b want 110", bus.core_run, bus.done, bus.error); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after_done: got %b want 0", bus.in_ready); end
        checks++; if (acc_cyc.size() != 13) begin errors++; $display("FAIL full_accepted: got %0d want 13", acc_cyc.size()); end
    endtask

    task automatic test_gaps();
        int g;
        do_reset();
        new_image(32'd2);
        add_word(32'h1122_3344);
        add_word(32'hAABB_CCDD);
        add_byte(csum);
        clear_log();
        send_image(1, g);
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL gap_wr_count: got %0d want 2", wr_addr.size()); end
        if (wr_addr.size() == 2 && acc_cyc.size() == 13) begin
            checks++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h1122_3344) begin errors++; $display("FAIL gap_wr0: got %h/%h", wr_addr[0], wr_data[0]); end
            checks++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'hAABB_CCDD) begin errors++; $display("FAIL gap_wr1: got %h/%h", wr_addr[1], wr_data[1]); end
            checks++; if (wr_cyc[0] != acc_cyc[7] + 1 || wr_cyc[1] != acc_cyc[11] + 1) begin errors++; $display("FAIL gap_wr_timing: got %0d,%0d want %0d,%0d", wr_cyc[0], wr_cyc[1], acc_cyc[7] + 1, acc_cyc[11] + 1); end
        end
        checks++; if (done_cyc != 14 + g) begin errors++; $display("FAIL gap_done_cycle: got %0d want %0d", done_cyc, 14 + g); end
    endtask

    task automatic test_bad_checksum();
        int g;
        do_reset();
        new_image(32'd1);
        add_word(32'h0000_00FF);
        add_byte(8'h00);
        clear_log();
        send_image(0, g);
        checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL bad_wr_count: got %0d want 1", wr_addr.size()); end
        if (wr_addr.size() == 1) begin
            checks++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0000_00FF || wr_cyc[0] != 9) begin errors++; $display("FAIL bad_wr0: got %h/%h@%0d want 00000000/000000ff@9", wr_addr[0], wr_data[0], wr_cyc[0]); end
        end
        checks++; if (err_cyc != 10) begin errors++; $display("FAIL bad_err_cycle: got %0d want 10", err_cyc); end
        checks++; if (done_cyc != -1) begin errors++; $display("FAIL bad_done_seen: got %0d want -1", done_cyc); end
        checks++; if (bus.core_run !== 1'b0 || bus.in_ready !== 1'b0 || bus.error !== 1'b1) begin errors++; $display("FAIL bad_outputs: run/ready/err got %b%b%b want 001", bus.core_run, bus.in_ready, bus.error); end
    endtask

    task automatic test_hdr_overflow();
        int g;
        do_reset();
        new_image(32'(IMEM_WORDS + 1));
        add_word(32'h1234_5678);
        clear_log();
        send_image(0, g);
        checks++; if (err_cyc != 5) begin errors++; $display("FAIL ovf_err_cycle: got %0d want 5", err_cyc); end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL ovf_wr_count: got %0d want 0", wr_addr.size()); end
        checks++; if (acc_cyc.size() != 4) begin errors++; $display("FAIL ovf_accepted: got %0d want 4", acc_cyc.size()); end
        // Low bits equal the capacity but an upper byte is set.
        do_reset();
        new_image(32'h0000_0104);
        add_word(32'h1234_5678);
        clear_log();
        send_image(0, g);
        checks++; if (err_cyc != 5 || wr_addr.size() != 0) begin errors++; $display("FAIL ovf_upper: err@%0d writes=%0d want err@5 writes=0", err_cyc, wr_addr.size()); end
    endtask

    task automatic test_zero_words();
        int g;
        do_reset();
        new_image(32'd0);
        add_byte(8'h00);
        clear_log();
        send_image(0, g);
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL zero_done_cycle: got %0d want 6", done_cyc); end
        checks++; if (wr_addr.size() != 0 || bus.error !== 1'b0) begin errors++; $display("FAIL zero_side: writes=%0d err=%b want 0/0", wr_addr.size(), bus.error); end
    endtask

    task automatic test_max_words();
        int g;
        logic [31:0] w[4];
        w = '{32'h0102_0304, 32'h0A0B_0C0D, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        do_reset();
        new_image(32'(IMEM_WORDS));
        for (int k = 0; k < 4; k++) add_word(w[k]);
        add_byte(csum);
        clear_log();
        send_image(0, g);
        checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL max_wr_count: got %0d want 4", wr_addr.size()); end
        if (wr_addr.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wr_addr[k] !== 32'(4 * k) || wr_data[k] !== w[k] || wr_cyc[k] != 9 + 4 * k) begin
                    errors++;
                    $display("FAIL max_wr%0d: got %h/%h@%0d want %h/%h@%0d", k, wr_addr[k], wr_data[k], wr_cyc[k], 32'(4 * k), w[k], 9 + 4 * k);
                end
            end
        end
        checks++; if (done_cyc != 22) begin errors++; $display("FAIL max_done_cycle: got %0d want 22", done_cyc); end
    endtask

    task automatic test_reset_mid_load();
        int g;
        do_reset();
        clear_log();
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'hEE);
        step(1'b1, 8'h77);
        do_reset();
        new_image(32'd1);
        add_word(32'h0403_0201);
        add_byte(csum);
        send_image(0, g);
        checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL mid_wr_count: got %0d want 1", wr_addr.size()); end
        if (wr_addr.size() == 1) begin
            checks++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0403_0201) begin errors++; $display("FAIL mid_wr0: got %h/%h want 00000000/04030201", wr_addr[0], wr_data[0]); end
        end
        checks++; if (bus.done !== 1'b1 || bus.core_run !== 1'b1 || bus.error !== 1'b0) begin errors++; $display("FAIL mid_outputs: done/run/err got %b%b%b want 110", bus.done, bus.core_run, bus.error); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_gaps();
        test_bad_checksum();
        test_hdr_overflow();
        test_zero_words();
        test_max_words();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
